dmem_lsu: RTL and testbench



---
 rtl/riscv_pkg.sv | 27 ++
 rtl/dmem_lsu_if.sv | 30 +++
 rtl/dmem_lsu_fmt.sv | 49 ++++
 rtl/dmem_lsu.sv | 136 +++++++++++++
 tb/tb_dmem_lsu.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 load/store definitions: funct3 size codes, LSU state type, data width
// and a helper that maps a funct3 size code to (access bytes - 1).
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } lsu_state_t;

  // funct3[1:0] carries the size for both loads and stores: 00 byte, 01 half, 10 word.
  function automatic logic [1:0] f3_size_m1(input logic [1:0] sz);
    case (sz)
      2'b00:   f3_size_m1 = 2'd0;
      2'b01:   f3_size_m1 = 2'd1;
      default: f3_size_m1 = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bus between the execute stage (master) and the data memory LSU (slave).
interface dmem_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);

  // A request transfers on a rising edge where req_valid and req_ready are both 1; the master
  // holds the request fields stable while req_valid is high and req_ready is low. rsp_valid is a
  // single-cycle pulse that carries rsp_rdata/rsp_err and has no backpressure.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lsu_fmt.sv
// Lane formatter: store byte-enables/data placement and load extract/extension over a
// two-word window {next word, addressed word}, so one copy serves both halves of a split access.
module dmem_lsu_fmt
  import riscv_pkg::*;
(
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [XLEN-1:0]   wdata,
  input  logic [2*XLEN-1:0] rwin,
  output logic              legal,
  output logic [1:0]        size_m1,
  output logic [7:0]        be,
  output logic [2*XLEN-1:0] wwin,
  output logic [XLEN-1:0]   rdata
);

  logic [3:0]      mask;
  logic [XLEN-1:0] rsh;

  always_comb begin
    legal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~we;
      default:          legal = 1'b0;
    endcase
  end

  assign size_m1 = f3_size_m1(funct3[1:0]);
  assign mask    = (size_m1 == 2'd3) ? 4'b1111 :
                   (size_m1 == 2'd1) ? 4'b0011 : 4'b0001;
  assign be      = {4'b0000, mask} << off;
  assign wwin    = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
  assign rsh     = XLEN'(rwin >> {off, 3'b000});

  always_comb begin
    rdata = '0;
    case (funct3)
      F3_B:    rdata = {{24{rsh[7]}}, rsh[7:0]};
      F3_H:    rdata = {{16{rsh[15]}}, rsh[15:0]};
      F3_W:    rdata = rsh;
      F3_BU:   rdata = {24'd0, rsh[7:0]};
      F3_HU:   rdata = {16'd0, rsh[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressed RV32 data memory with LSU front end. Define MISALIGNED_SPLIT_EN to execute
// word-crossing misaligned accesses as two halves (IDLE -> SPLIT); otherwise they fault.
module dmem_lsu
  import riscv_pkg::lsu_state_t, riscv_pkg::IDLE, riscv_pkg::SPLIT;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 32,
  parameter int XLEN      = 32
) (
  input  logic       clk,
  input  logic       rst,
  dmem_lsu_if.slave  bus,
  output lsu_state_t dbg_state
);

  localparam int WORDS = MEM_DEPTH / 4;
  localparam int WA    = $clog2(WORDS);

  logic [XLEN-1:0] mem [WORDS];
  lsu_state_t      state;

  logic            l_we;
  logic [2:0]      l_f3;
  logic [1:0]      l_off;
  logic [WA-1:0]   l_widx;
  logic [XLEN-1:0] l_wdata;

  logic              in_split, accept;
  logic              f_we;
  logic [2:0]        f_f3;
  logic [1:0]        f_off;
  logic [WA-1:0]     f_widx, f_widx_hi;
  logic [XLEN-1:0]   f_wdata;
  logic              f_legal;
  logic [1:0]        f_size_m1;
  logic [7:0]        f_be;
  logic [2*XLEN-1:0] f_wwin;
  logic [XLEN-1:0]   f_rdata;
  logic [ADDR_W:0]   last_addr;
  logic              range_err, align_err, go_split, acc_err, wr_lo, wr_hi;

  assign in_split  = (state == SPLIT);
  assign accept    = bus.req_valid & bus.req_ready & ~in_split;
  assign dbg_state = state;

  // In SPLIT the formatter replays the latched request; it writes the upper window lanes.
  assign f_we      = in_split ? l_we    : bus.req_we;
  assign f_f3      = in_split ? l_f3    : bus.req_funct3;
  assign f_off     = in_split ? l_off   : bus.req_addr[1:0];
  assign f_widx    = in_split ? l_widx  : bus.req_addr[WA+1:2];
  assign f_wdata   = in_split ? l_wdata : bus.req_wdata;
  assign f_widx_hi = f_widx + WA'(1);

  dmem_lsu_fmt u_fmt (
    .we      (f_we),
    .funct3  (f_f3),
    .off     (f_off),
    .wdata   (f_wdata),
    .rwin    ({mem[f_widx_hi], mem[f_widx]}),
    .legal   (f_legal),
    .size_m1 (f_size_m1),
    .be      (f_be),
    .wwin    (f_wwin),
    .rdata   (f_rdata)
  );

  // Last touched byte, one bit wider than the address so the check never wraps.
  assign last_addr = {1'b0, bus.req_addr} + {{(ADDR_W-1){1'b0}}, f_size_m1};
  assign range_err = last_addr >= (ADDR_W+1)'(MEM_DEPTH);

`ifdef MISALIGNED_SPLIT_EN
  assign align_err = 1'b0;
  assign go_split  = ({1'b0, f_off} + {1'b0, f_size_m1}) > 3'd3;
`else
  assign align_err = (f_size_m1 == 2'd1 && f_off[0]) || (f_size_m1 == 2'd3 && f_off != 2'd0);
  assign go_split  = 1'b0;
`endif

  assign acc_err = ~f_legal | range_err | align_err;
  assign wr_lo   = accept & f_we & ~acc_err & ~rst;
  assign wr_hi   = in_split & l_we & ~rst;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_lo && f_be[i])
        mem[f_widx][8*i +: 8] <= f_wwin[8*i +: 8];
      if (wr_hi && f_be[4+i])
        mem[f_widx_hi][8*i +: 8] <= f_wwin[XLEN + 8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && go_split && !acc_err) begin
      l_we    <= bus.req_we;
      l_f3    <= bus.req_funct3;
      l_off   <= bus.req_addr[1:0];
      l_widx  <= bus.req_addr[WA+1:2];
      l_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (go_split && !acc_err) begin
              state         <= SPLIT;
              bus.req_ready <= 1'b0;
            end else begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= acc_err;
              bus.rsp_rdata <= (acc_err || bus.req_we) ? '0 : f_rdata;
            end
          end
        end
        SPLIT: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= l_we ? '0 : f_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: driver pushes expected responses, a negedge monitor pops and compares.
module tb_dmem_lsu;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  lsu_state_t dbg_state;

  dmem_lsu_if #(.ADDR_W(32), .XLEN(32)) bus ();

  dmem_lsu #(.MEM_DEPTH(1024), .ADDR_W(32), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int unsigned exp_cyc_q[$];
  string       exp_name_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with no request outstanding",
                 bus.rsp_rdata, bus.rsp_err);
      end else begin
        automatic logic [31:0] e_rd  = exp_q.pop_front();
        automatic logic        e_err = exp_err_q.pop_front();
        automatic int unsigned e_cyc = exp_cyc_q.pop_front();
        automatic string       nm    = exp_name_q.pop_front();
        check(nm, bus.rsp_rdata, e_rd);
        check({nm, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e_err});
        check({nm, "_lat"}, cyc, e_cyc);
      end
    end
  end

  task automatic drive(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int unsigned lat, input bit expect_rsp);
    int waited;
    waited = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      bus.req_valid = 1'b0;
      waited++;
      @(negedge clk);
    end
    if (bus.req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: got req_ready %0b expected 1", name, bus.req_ready);
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    if (expect_rsp) begin
      exp_q.push_back(exp_rd);
      exp_err_q.push_back(exp_err);
      exp_cyc_q.push_back(cyc + lat);
      exp_name_q.push_back(name);
    end
    @(posedge clk);
  endtask

  task automatic ld(input string name, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] exp_rd, input logic exp_err, input int unsigned lat);
    drive(name, 1'b0, f3, addr, 32'd0, exp_rd, exp_err, lat, 1'b1);
  endtask

  task automatic st(input string name, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic exp_err, input int unsigned lat);
    drive(name, 1'b1, f3, addr, wdata, 32'd0, exp_err, lat, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
    rst = 1'b0;

`ifdef MISALIGNED_SPLIT_EN
    st("t4_sw_0e", F3_W, 32'h0E, 32'h11223344, 1'b0, 2);
    #1 check("t4_ready_low", {31'd0, bus.req_ready}, 32'd0);
    ld("t4_lw_0c", F3_W, 32'h0C, 32'h33440000, 1'b0, 1);
    ld("t4_lw_10", F3_W, 32'h10, 32'h00001122, 1'b0, 1);
    ld("t4_lw_0e", F3_W, 32'h0E, 32'h11223344, 1'b0, 2);
    #1 check("t4_split_state", {31'd0, dbg_state}, {31'd0, SPLIT});
    drive("t6_sw_1e", 1'b1, F3_W, 32'h1E, 32'hA1B2C3D4, 32'd0, 1'b0, 2, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_state_idle", {31'd0, dbg_state}, {31'd0, IDLE});
    check("t6_ready", {31'd0, bus.req_ready}, 32'd1);
    ld("t6_lw_1c", F3_W, 32'h1C, 32'hC3D40000, 1'b0, 1);
    ld("t6_lw_20", F3_W, 32'h20, 32'h00000000, 1'b0, 1);
`endif

    st("t1_sw_10", F3_W, 32'h10, 32'hDEADBEEF, 1'b0, 1);
    ld("t1_lw_10", F3_W, 32'h10, 32'hDEADBEEF, 1'b0, 1);
    st("t2_sb_13", F3_B, 32'h13, 32'h12345680, 1'b0, 1);
    ld("t2_lb_13", F3_B, 32'h13, 32'hFFFFFF80, 1'b0, 1);
    ld("t2_lbu_13", F3_BU, 32'h13, 32'h00000080, 1'b0, 1);
    ld("t2_lw_10", F3_W, 32'h10, 32'h80ADBEEF, 1'b0, 1);
    ld("t2_lh_12", F3_H, 32'h12, 32'hFFFF80AD, 1'b0, 1);
    ld("t2_lhu_12", F3_HU, 32'h12, 32'h000080AD, 1'b0, 1);
    ld("t2_lb_10", F3_B, 32'h10, 32'hFFFFFFEF, 1'b0, 1);
    ld("t2_lbu_11", F3_BU, 32'h11, 32'h000000BE, 1'b0, 1);
    st("t2_sh_16", F3_H, 32'h16, 32'hABCD1234, 1'b0, 1);
    ld("t2_lw_14", F3_W, 32'h14, 32'h12340000, 1'b0, 1);

    st("t3_sh_3ff", F3_H, 32'h3FF, 32'h0000BEEF, 1'b1, 1);
    ld("t3_lw_3fc", F3_W, 32'h3FC, 32'h00000000, 1'b0, 1);
    ld("t3_lw_400", F3_W, 32'h400, 32'h00000000, 1'b1, 1);
    ld("t3_lw_hiaddr", F3_W, 32'h80000010, 32'h00000000, 1'b1, 1);
    ld("t3_ld_f3_011", 3'b011, 32'h10, 32'h00000000, 1'b1, 1);
    st("t3_st_f3_100", 3'b100, 32'h10, 32'h00000055, 1'b1, 1);
    ld("t3_lw_10_kept", F3_W, 32'h10, 32'h80ADBEEF, 1'b0, 1);
    st("t3_sw_3fc", F3_W, 32'h3FC, 32'h55AA55AA, 1'b0, 1);
    ld("t3_lw_3fc_new", F3_W, 32'h3FC, 32'h55AA55AA, 1'b0, 1);

`ifdef MISALIGNED_SPLIT_EN
    ld("t4_lw_11", F3_W, 32'h11, 32'h0080ADBE, 1'b0, 2);
    ld("t4_lh_11", F3_H, 32'h11, 32'hFFFFADBE, 1'b0, 1);
    ld("t4_lhu_13", F3_HU, 32'h13, 32'h00000080, 1'b0, 2);
`else
    ld("t4_lw_11", F3_W, 32'h11, 32'h00000000, 1'b1, 1);
    ld("t4_lh_11", F3_H, 32'h11, 32'h00000000, 1'b1, 1);
    st("t4_sw_12", F3_W, 32'h12, 32'hFFFFFFFF, 1'b1, 1);
    ld("t4_lw_10_kept", F3_W, 32'h10, 32'h80ADBEEF, 1'b0, 1);
`endif

    st("t5_sw_20", F3_W, 32'h20, 32'hCAFEF00D, 1'b0, 1);
    #1 check("t5_ready_held", {31'd0, bus.req_ready}, 32'd1);
    ld("t5_lw_20", F3_W, 32'h20, 32'hCAFEF00D, 1'b0, 1);

    @(negedge clk);
    bus.req_valid = 1'b0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d responses outstanding expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
